plru_array: RTL and testbench

- Multi-set, parametrised tree pseudo-LRU replacement unit for set-associative caches.
- Holds one (NUM_WAYS-1)-bit PLRU tree per set and accepts MRU "touch" updates from the hit/fill path.
- Returns a registered victim way per lookup. A valid-way mask can override the tree (prefers invalid ways).
- Provides a multi-cycle flush that walks every set back to the reset state. Sits beside the tag/data arrays in the cache datapath.

---
 rtl/plru_pkg.sv | 16 +
 rtl/plru_tree.sv | 39 +++
 rtl/plru_array.sv | 121 ++++++++++++
 tb/tb_plru_array.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// Shared types and constants for the tree pseudo-LRU replacement array.
// Trees are sized for the widest supported associativity; modules slice what they need.
package plru_pkg;

    localparam int MAX_WAYS = 32;

    typedef logic [MAX_WAYS-2:0] tree_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    localparam tree_t PLRU_RESET = '1;

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU core: applies an MRU touch to one tree and decodes its victim.
// Heap-ordered nodes; a node bit of 1 steers the victim toward the lower-numbered half.
module plru_tree #(
    parameter int NUM_WAYS = 8,
    localparam int W_WAY   = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] tree,
    input  logic [W_WAY-1:0]    touch_way,
    output logic [NUM_WAYS-2:0] tree_next,
    output logic [W_WAY-1:0]    victim
);

    // A node lies on the touched way's path when the way's upper bits match the node position.
    for (genvar n = 0; n < NUM_WAYS - 1; n++) begin : g_node
        localparam int LEVEL = $clog2(n + 2) - 1;
        localparam int POS   = n + 1 - 2 ** LEVEL;

        logic on_path;

        assign on_path      = (touch_way >> (W_WAY - LEVEL)) == W_WAY'(POS);
        assign tree_next[n] = on_path ? touch_way[W_WAY-1-LEVEL] : tree[n];
    end

    // Padding to NUM_WAYS bits lets a W_WAY-wide node index address the tree exactly.
    logic [NUM_WAYS-1:0] padded;
    logic [W_WAY-1:0]    node;

    assign padded = {1'b0, tree};

    always_comb begin
        node   = '0;
        victim = '0;
        for (int d = 0; d < W_WAY; d++) begin
            victim[W_WAY-1-d] = ~padded[node];
            node = (node << 1) + (padded[node] ? W_WAY'(1) : W_WAY'(2));
        end
    end

endmodule

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU state with registered victim lookup, MRU touch updates,
// an invalid-way override and a walking flush back to the reset state.
module plru_array
    import plru_pkg::*;
#(
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 8,
    localparam int W_WAY   = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_valid,
    input  logic [S_INDEX-1:0]  rd_index,
    input  logic [NUM_WAYS-1:0] inv_mask,
    input  logic                upd_valid,
    input  logic [S_INDEX-1:0]  upd_index,
    input  logic [W_WAY-1:0]    upd_way,
    input  logic                flush_req,
    output logic                victim_valid,
    output logic [W_WAY-1:0]    victim_way,
    output logic                victim_inv,
    output logic                busy
);

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int W_TREE   = NUM_WAYS - 1;
    localparam logic [W_TREE-1:0] TREE_ONES = PLRU_RESET[W_TREE-1:0];

    state_t             state;
    logic [S_INDEX-1:0] ptr;
    logic [W_TREE-1:0]  trees [NUM_SETS];

    logic              rd_go;
    logic              upd_go;
    logic [W_TREE-1:0] upd_tree_next;
    logic [W_TREE-1:0] lookup_tree;
    logic [W_TREE-1:0] unused_lookup_next;
    logic [W_WAY-1:0]  tree_victim;
    logic [W_WAY-1:0]  unused_upd_victim;
    logic [W_WAY-1:0]  inv_way;

    assign rd_go  = rd_valid && (state == IDLE);
    assign upd_go = upd_valid && (state == IDLE);

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_upd_tree (
        .tree      (trees[upd_index]),
        .touch_way (upd_way),
        .tree_next (upd_tree_next),
        .victim    (unused_upd_victim)
    );

    // Write-first: a lookup of the set being touched sees the post-touch tree.
    assign lookup_tree = (upd_go && (upd_index == rd_index)) ? upd_tree_next : trees[rd_index];

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_lookup_tree (
        .tree      (lookup_tree),
        .touch_way (upd_way),
        .tree_next (unused_lookup_next),
        .victim    (tree_victim)
    );

    always_comb begin
        inv_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (inv_mask[i]) begin
                inv_way = W_WAY'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                trees[s] <= TREE_ONES;
            end
        end else if (state == FLUSH) begin
            trees[ptr] <= TREE_ONES;
        end else if (upd_go) begin
            trees[upd_index] <= upd_tree_next;
        end
    end

    // The invalid-way override only affects the reported victim, never the tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            busy         <= 1'b0;
            victim_valid <= 1'b0;
            victim_way   <= '0;
            victim_inv   <= 1'b0;
        end else begin
            victim_valid <= rd_go;
            if (rd_go) begin
                victim_inv <= |inv_mask;
                victim_way <= (|inv_mask) ? inv_way : tree_victim;
            end
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= FLUSH;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FLUSH: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plru_array.sv
// Bench for plru_array: 8-way and 4-way instances driven with shared stimulus and checked
// against a recency-timestamp model of tree PLRU, plus directed hand-computed cases.
module tb_plru_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_valid = 1'b0;
    logic [2:0] rd_index = '0;
    logic [7:0] inv_mask = '0;
    logic       upd_valid = 1'b0;
    logic [2:0] upd_index = '0;
    logic [2:0] upd_way = '0;
    logic       flush_req = 1'b0;

    logic       victim_valid, victim_inv, busy;
    logic [2:0] victim_way;
    logic       victim_valid4, victim_inv4, busy4;
    logic [1:0] victim_way4;
    logic [1:0] upd_way4;
    logic [3:0] inv_mask4;

    assign upd_way4  = upd_way[1:0];
    assign inv_mask4 = inv_mask[3:0];

    int n_compared = 0;
    int n_failed   = 0;

    // Model: per set, the time each way was last touched (0 = never / since flush).
    int stamp = 0;
    int ts8 [8][8];
    int ts4 [8][8];
    bit exp_valid = 1'b0;
    bit exp_busy  = 1'b0;
    int exp_way8  = 0;
    int exp_way4  = 0;
    bit exp_inv8  = 1'b0;
    bit exp_inv4  = 1'b0;
    int fptr      = 0;

    always #5 clk = ~clk;

    plru_array #(.S_INDEX(3), .NUM_WAYS(8)) dut (
        .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_index(rd_index), .inv_mask(inv_mask),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way), .flush_req(flush_req),
        .victim_valid(victim_valid), .victim_way(victim_way), .victim_inv(victim_inv), .busy(busy)
    );

    plru_array #(.S_INDEX(3), .NUM_WAYS(4)) dut4 (
        .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_index(rd_index), .inv_mask(inv_mask4),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way4), .flush_req(flush_req),
        .victim_valid(victim_valid4), .victim_way(victim_way4), .victim_inv(victim_inv4), .busy(busy4)
    );

    // Tree PLRU victim: at each split, go away from the half holding the most recent touch;
    // with no touches on either side the lower half is chosen.
    function automatic int victim_of(input int row [8], input int nways);
        int lo = 0;
        int size = nways;
        int half, ml, mu;
        while (size > 1) begin
            half = size / 2;
            ml = 0;
            mu = 0;
            for (int i = 0; i < half; i++) begin
                if (row[lo + i] > ml) ml = row[lo + i];
                if (row[lo + half + i] > mu) mu = row[lo + half + i];
            end
            if (ml > mu) lo += half;
            size = half;
        end
        return lo;
    endfunction

    task automatic predict(input int mask, input int nways, input int row [8],
                           output int way, output bit inv);
        way = -1;
        for (int i = 0; i < nways; i++) begin
            if (mask[i] && way < 0) way = i;
        end
        inv = (way >= 0);
        if (way < 0) way = victim_of(row, nways);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 8; s++) begin
                for (int w = 0; w < 8; w++) begin
                    ts8[s][w] = 0;
                    ts4[s][w] = 0;
                end
            end
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            exp_way8  = 0;
            exp_way4  = 0;
            exp_inv8  = 1'b0;
            exp_inv4  = 1'b0;
            fptr      = 0;
        end else if (exp_busy) begin
            for (int w = 0; w < 8; w++) begin
                ts8[fptr][w] = 0;
                ts4[fptr][w] = 0;
            end
            exp_valid = 1'b0;
            if (fptr == 7) exp_busy = 1'b0;
            fptr++;
        end else begin
            if (upd_valid) begin
                stamp++;
                ts8[upd_index][upd_way] = stamp;
                ts4[upd_index][upd_way % 4] = stamp;
            end
            exp_valid = rd_valid;
            if (rd_valid) begin
                predict(int'(inv_mask), 8, ts8[rd_index], exp_way8, exp_inv8);
                predict(int'(inv_mask) & 15, 4, ts4[rd_index], exp_way4, exp_inv4);
            end
            if (flush_req) begin
                exp_busy = 1'b1;
                fptr = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pin(input string name, input int dut_val, input int model_val, input int lit);
        checkOutput({name, " dut"}, dut_val, lit);
        checkOutput({name, " model"}, model_val, lit);
    endtask

    task automatic applyStimulus(input bit rv, input int ri, input int m, input bit uv,
                                 input int ui, input int uw, input bit fr);
        @(negedge clk);
        rd_valid  = rv;
        rd_index  = 3'(ri);
        inv_mask  = 8'(m);
        upd_valid = uv;
        upd_index = 3'(ui);
        upd_way   = 3'(uw);
        flush_req = fr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic lookup(input int set, input int mask);
        applyStimulus(1'b1, set, mask, 1'b0, 0, 0, 1'b0);
        idle();
    endtask

    task automatic touch(input int set, input int way);
        applyStimulus(1'b0, 0, 0, 1'b1, set, way, 1'b0);
    endtask

    task automatic allSetsVictimZero(input string tag);
        for (int s = 0; s < 8; s++) begin
            lookup(s, 0);
            pin({tag, " way8"}, int'(victim_way), exp_way8, 0);
            pin({tag, " way4"}, int'(victim_way4), exp_way4, 0);
        end
    endtask

    // Continuous check of both instances against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("busy", int'(busy), int'(exp_busy));
            checkOutput("busy4", int'(busy4), int'(exp_busy));
            checkOutput("victim_valid", int'(victim_valid), int'(exp_valid));
            checkOutput("victim_valid4", int'(victim_valid4), int'(exp_valid));
            if (exp_valid) begin
                checkOutput("victim_way", int'(victim_way), exp_way8);
                checkOutput("victim_inv", int'(victim_inv), int'(exp_inv8));
                checkOutput("victim_way4", int'(victim_way4), exp_way4);
                checkOutput("victim_inv4", int'(victim_inv4), int'(exp_inv4));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        #12;
        checkOutput("reset victim_valid", int'(victim_valid), 0);
        checkOutput("reset victim_way", int'(victim_way), 0);
        checkOutput("reset victim_inv", int'(victim_inv), 0);
        checkOutput("reset busy", int'(busy), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        $display("[TB] reset-state lookup");
        lookup(0, 0);
        pin("reset lookup way8", int'(victim_way), exp_way8, 0);
        pin("reset lookup inv8", int'(victim_inv), int'(exp_inv8), 0);
        pin("reset lookup way4", int'(victim_way4), exp_way4, 0);

        $display("[TB] touch-order sequence on set 2");
        touch(2, 0); touch(2, 4); touch(2, 2); touch(2, 6);
        touch(2, 1); touch(2, 5); touch(2, 3);
        lookup(2, 0);
        pin("touch order way8", int'(victim_way), exp_way8, 7);
        touch(2, 7);
        lookup(2, 0);
        pin("after touch 7 way8", int'(victim_way), exp_way8, 0);
        lookup(3, 0);
        pin("untouched set3 way8", int'(victim_way), exp_way8, 0);
        pin("untouched set3 way4", int'(victim_way4), exp_way4, 0);

        $display("[TB] same-cycle bypass");
        applyStimulus(1'b1, 5, 0, 1'b1, 5, 0, 1'b0);
        idle();
        pin("bypass way8", int'(victim_way), exp_way8, 4);
        lookup(4, 0);
        pin("other set way8", int'(victim_way), exp_way8, 0);

        $display("[TB] invalid-mask override");
        lookup(1, 8'b0010_1000);
        pin("inv mask way8", int'(victim_way), exp_way8, 3);
        pin("inv mask inv8", int'(victim_inv), int'(exp_inv8), 1);
        pin("inv mask way4", int'(victim_way4), exp_way4, 3);
        lookup(1, 0);
        pin("after mask way8", int'(victim_way), exp_way8, 0);
        pin("after mask inv8", int'(victim_inv), int'(exp_inv8), 0);

        $display("[TB] 4-way touch order on set 6");
        touch(6, 0); touch(6, 2); touch(6, 1);
        lookup(6, 0);
        pin("4way order way4", int'(victim_way4), exp_way4, 3);
        pin("4way order way8", int'(victim_way), exp_way8, 4);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 0,
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), ($urandom_range(0, 49) == 0));
        end
        repeat (12) idle();

        $display("[TB] flush with dropped traffic");
        for (int s = 0; s < 8; s++) touch(s, int'($urandom_range(0, 7)));
        applyStimulus(1'b1, 2, 0, 1'b1, 2, 7, 1'b1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            rd_valid  = 1'b1;
            rd_index  = 3'($urandom_range(0, 7));
            upd_valid = 1'b1;
            upd_index = 3'($urandom_range(0, 7));
            upd_way   = 3'($urandom_range(0, 7));
            flush_req = 1'($urandom_range(0, 1));
        end
        rd_valid  = 1'b0;
        upd_valid = 1'b0;
        flush_req = 1'b0;
        checkOutput("flush busy cycles", cnt, 8);
        allSetsVictimZero("post flush");

        $display("[TB] reset during flush");
        for (int s = 0; s < 8; s++) touch(s, int'($urandom_range(0, 7)));
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        idle(); idle(); idle();
        #2 rst = 1'b1;
        #1;
        checkOutput("mid-flush reset busy", int'(busy), 0);
        checkOutput("mid-flush reset busy4", int'(busy4), 0);
        checkOutput("mid-flush reset victim_valid", int'(victim_valid), 0);
        #4 rst = 1'b0;
        allSetsVictimZero("post reset");

        repeat (2) idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
